// File: rtl/cuenta_regresiva_pkg.sv
// cuenta_regresiva_pkg: shared FSM state encoding, BCD limits and preset clamp helper
package cuenta_regresiva_pkg;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;
   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] BCD_TENS_MAX = 4'd5;
   localparam logic [3:0] BCD_ZERO     = 4'd0;
   function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction
endpackage

// File: rtl/digito_bcd_desc.sv
// digito_bcd_desc: one BCD digit down-counter that wraps 0 -> MAX and borrows from the next digit
//   clk, reset (sync, active high)
//   load/value : parallel load (wins over dec)
//   dec        : decrement request; borrow is high when dec hits a zero digit
//   q          : registered digit
module digito_bcd_desc
   import cuenta_regresiva_pkg::*;
#(
   parameter logic [3:0] MAX = BCD_MAX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       dec,
   input  logic [3:0] value,
   output logic [3:0] q,
   output logic       borrow
);
   assign borrow = dec && q == BCD_ZERO;
   always_ff @(posedge clk)
      if (reset) q <= BCD_ZERO;
      else if (load) q <= value;
      else if (dec) q <= borrow ? MAX : q - 4'd1;
endmodule

// File: rtl/cuenta_regresiva.sv
// cuenta_regresiva: mm:ss.cc BCD countdown timer with IDLE/RUN/PAUSE/ALARM control
//   clk, reset (sync, active high), tick (centisecond strobe)
//   load/start/stop controls, set_* preset digits (clamped to valid BCD on load)
//   min_*/sec_*/psec_* registered count digits; running, done (one-clk pulse), alarm
//   Build option CUENTA_REGRESIVA_AUTORELOAD_EN: keep last preset and restart from it after ALARM.
module cuenta_regresiva
   import cuenta_regresiva_pkg::*;
#(
   parameter int ALARM_TICKS = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] set_min_high,
   input  logic [3:0] set_min_low,
   input  logic [3:0] set_sec_high,
   input  logic [3:0] set_sec_low,
   output logic [3:0] min_high,
   output logic [3:0] min_low,
   output logic [3:0] sec_high,
   output logic [3:0] sec_low,
   output logic [3:0] psec_high,
   output logic [3:0] psec_low,
   output logic       running,
   output logic       done,
   output logic       alarm
);
   localparam int AW = $clog2(ALARM_TICKS + 1);
   state_t        state;
   logic [AW-1:0] acnt;
   logic [23:0]   cnt;
   logic [15:0]   preset_c, reload_val;
   logic [23:0]   dval;
   logic [6:0]    b;
   logic          load_ok, reload, alarm_end, is_one, is_zero, dig_load, unused_borrow;
   assign preset_c  = {bcd_clamp(set_min_high, BCD_TENS_MAX), bcd_clamp(set_min_low, BCD_MAX),
                       bcd_clamp(set_sec_high, BCD_TENS_MAX), bcd_clamp(set_sec_low, BCD_MAX)};
   assign load_ok   = load && state != RUN;
   assign alarm_end = state == ALARM && tick && acnt == AW'(ALARM_TICKS - 1);
   assign is_one    = cnt == 24'h000001;
   assign is_zero   = cnt == 24'h000000;
`ifdef CUENTA_REGRESIVA_AUTORELOAD_EN
   logic [15:0] stored;
   always_ff @(posedge clk)
      if (reset) stored <= '0;
      else if (load_ok) stored <= preset_c;
   assign reload     = alarm_end && stored != '0;
   assign reload_val = stored;
`else
   assign reload     = 1'b0;
   assign reload_val = '0;
`endif
   assign dig_load = load_ok || reload;
   // psec digits always load as zero; explicit load beats the autoreload source
   assign dval = {load_ok ? preset_c : reload_val, BCD_ZERO, BCD_ZERO};
   assign b[0] = tick && state == RUN;
   // digit order low to high: psec_low, psec_high, sec_low, sec_high, min_low, min_high
   for (genvar i = 0; i < 6; i++) begin : g_dig
      digito_bcd_desc #(.MAX((i == 3 || i == 5) ? BCD_TENS_MAX : BCD_MAX)) u_dig (
         .clk(clk), .reset(reset), .load(dig_load), .dec(b[i]),
         .value(dval[4*i +: 4]), .q(cnt[4*i +: 4]), .borrow(b[i+1]));
   end
   // the count never decrements below zero, so the top borrow never fires
   assign unused_borrow = b[6];
   assign {min_high, min_low, sec_high, sec_low, psec_high, psec_low} = cnt;
   always_ff @(posedge clk)
      if (reset) begin
         state   <= IDLE;
         running <= 1'b0;
         done    <= 1'b0;
         alarm   <= 1'b0;
         acnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, PAUSE:
               if (load) state <= IDLE;
               else if (start && !stop && !is_zero) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            RUN:
               if (tick && is_one) begin
                  state   <= ALARM;
                  running <= 1'b0;
                  alarm   <= 1'b1;
                  done    <= 1'b1;
                  acnt    <= '0;
               end else if (stop) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end
            ALARM:
               if (load) begin
                  state <= IDLE;
                  alarm <= 1'b0;
                  acnt  <= '0;
               end else if (alarm_end) begin
                  state   <= reload ? RUN : IDLE;
                  running <= reload;
                  alarm   <= 1'b0;
                  acnt    <= '0;
               end else if (tick) acnt <= acnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_cuenta_regresiva.sv
// tb_cuenta_regresiva: directed-vector check of the countdown timer with hand-computed BCD counts
module tb_cuenta_regresiva;
   logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
   logic [3:0] smh = 0, sml = 0, ssh = 0, ssl = 0;
   logic [3:0] min_high, min_low, sec_high, sec_low, psec_high, psec_low;
   logic       running, done, alarm;
   int         vecs = 0, miss = 0, ndone = 0, n0;
   logic [23:0] cnt;
   assign cnt = {min_high, min_low, sec_high, sec_low, psec_high, psec_low};

   cuenta_regresiva dut (
      .clk(clk), .reset(reset), .tick(tick), .load(load), .start(start), .stop(stop),
      .set_min_high(smh), .set_min_low(sml), .set_sec_high(ssh), .set_sec_low(ssl),
      .min_high(min_high), .min_low(min_low), .sec_high(sec_high), .sec_low(sec_low),
      .psec_high(psec_high), .psec_low(psec_low),
      .running(running), .done(done), .alarm(alarm));

   always #5 clk = ~clk;
   always @(negedge clk) if (done) ndone++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      cyc(n);
      tick = 1'b0;
   endtask

   task automatic preset(input logic [3:0] mh, ml, sh, sl);
      smh = mh; sml = ml; ssh = sh; ssl = sl;
      load = 1'b1;
      cyc(1);
      load = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
   endtask

   initial begin
      cyc(2);
      check("rst_cnt", cnt, 24'h000000);
      check("rst_flags", {running, done, alarm}, 3'b000);
      reset = 1'b0;

      // countdown to zero, done pulse and full alarm window
      preset(0, 0, 0, 1);
      check("load_0001", cnt, 24'h000100);
      go();
      check("run_on", running, 1'b1);
      ticks(98);
      check("at_0002", cnt, 24'h000002);
      n0 = ndone;
      ticks(1);
      check("at_0001", {cnt, done}, {24'h000001, 1'b0});
      ticks(1);
      check("zero_hit", {cnt, done, alarm, running}, {24'h000000, 3'b110});
      cyc(1);
      check("done_clr", done, 1'b0);
      ticks(99);
      check("alarm_99", alarm, 1'b1);
      ticks(1);
      check("alarm_end", alarm, 1'b0);
      check("done_once", ndone - n0, 1);
`ifdef CUENTA_REGRESIVA_AUTORELOAD_EN
      check("reload_cnt", {cnt, running}, {24'h000100, 1'b1});
`else
      check("end_idle", {cnt, running}, {24'h000000, 1'b0});
`endif
      do_reset();

      // minute borrow
      preset(0, 1, 0, 0);
      go();
      ticks(1);
      check("borrow_min", cnt, 24'h005999);
      ticks(1);
      check("borrow_nxt", cnt, 24'h005998);
      do_reset();

      // stop with tick, pause holds, resume, load ignored in RUN
      preset(0, 0, 1, 0);
      go();
      tick = 1'b1; stop = 1'b1;
      cyc(1);
      tick = 1'b0; stop = 1'b0;
      check("stop_tick", {cnt, running}, {24'h000999, 1'b0});
      ticks(3);
      check("pause_hold", cnt, 24'h000999);
      start = 1'b1; stop = 1'b1;
      cyc(1);
      start = 1'b0; stop = 1'b0;
      check("stop_wins", running, 1'b0);
      go();
      ticks(1);
      check("resume", {cnt, running}, {24'h000998, 1'b1});
      preset(0, 0, 0, 0);
      check("load_in_run", {cnt, running}, {24'h000998, 1'b1});
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;

      // clamping and zero-start
      preset(0, 12, 7, 0);
      check("clamp_a", cnt, 24'h095000);
      preset(9, 15, 6, 10);
      check("clamp_max", cnt, 24'h595900);
      go();
      ticks(1);
      check("from_max", cnt, 24'h595899);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      preset(0, 0, 0, 0);
      go();
      check("zero_start", {cnt, running}, {24'h000000, 1'b0});
      smh = 0; sml = 0; ssh = 0; ssl = 5;
      load = 1'b1; start = 1'b1;
      cyc(1);
      load = 1'b0; start = 1'b0;
      check("load_start", {cnt, running}, {24'h000500, 1'b0});

      // reset mid-RUN
      go();
      check("run_0500", {cnt, running}, {24'h000500, 1'b1});
      n0 = ndone;
      reset = 1'b1;
      cyc(1);
      check("rst_run", {cnt, running, done, alarm}, {24'h000000, 3'b000});
      reset = 1'b0;
      cyc(1);
      check("rst_nodone", ndone - n0, 0);

      // zero with stop, start ignored in ALARM, reset mid-ALARM
      preset(0, 0, 0, 1);
      go();
      ticks(99);
      tick = 1'b1; stop = 1'b1;
      cyc(1);
      tick = 1'b0; stop = 1'b0;
      check("zero_stop", {cnt, done, alarm, running}, {24'h000000, 3'b110});
      go();
      check("alarm_start", {alarm, running}, 2'b10);
      n0 = ndone;
      reset = 1'b1;
      cyc(1);
      check("rst_alarm", {alarm, done, running}, 3'b000);
      reset = 1'b0;
      cyc(2);
      check("rst_al_nodone", ndone - n0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
